leaf_user_fifo_bank: RTL and testbench

- Parametrised buffering stage between leaf_interface and the user kernel in a leaf shell.
- Supports any NUM_IN_PORTS / NUM_OUT_PORTS combination.
- Each inbound port (interface->user) and each outbound port (user->interface) gets an independent first-word-fall-through FIFO with a vld/ack handshake.
- Decouples kernel stalls from the interface, and freezes outbound traffic while resend is asserted.

---
 rtl/leaf_user_fifo_bank_if.sv | 47 ++++
 rtl/leaf_user_fifo_bank.sv | 153 +++++++++++++++
 tb/tb_leaf_user_fifo_bank.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/leaf_user_fifo_bank_if.sv
// Purpose: bundles every data/handshake signal between the FIFO bank, leaf_interface and the user kernel.
// Latency: none; this is wiring only.
// Backpressure: carries the vld/ack pairs unchanged. The master side is the environment and the slave side is the bank.
// Optional macro LEAF_FIFO_STATS_EN adds stats_clr and xfer_count.
interface leaf_user_fifo_bank_if #(
    parameter int PAYLOAD_BITS  = 32,
    parameter int NUM_IN_PORTS  = 4,
    parameter int NUM_OUT_PORTS = 3,
    parameter int DEPTH_BITS    = 3
);
    logic                                               resend;
    logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]               in_data;
    logic [NUM_IN_PORTS-1:0]                            in_vld;
    logic [NUM_IN_PORTS-1:0]                            in_ack;
    logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]               user_in_data;
    logic [NUM_IN_PORTS-1:0]                            user_in_vld;
    logic [NUM_IN_PORTS-1:0]                            user_in_ack;
    logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]              user_out_data;
    logic [NUM_OUT_PORTS-1:0]                           user_out_vld;
    logic [NUM_OUT_PORTS-1:0]                           user_out_ack;
    logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]              out_data;
    logic [NUM_OUT_PORTS-1:0]                           out_vld;
    logic [NUM_OUT_PORTS-1:0]                           out_ack;
    logic [(NUM_IN_PORTS+NUM_OUT_PORTS)*(DEPTH_BITS+1)-1:0] fifo_level;
`ifdef LEAF_FIFO_STATS_EN
    logic                                               stats_clr;
    logic [(NUM_IN_PORTS+NUM_OUT_PORTS)*16-1:0]         xfer_count;
`endif

    modport master (
        output resend, in_data, in_vld, user_in_ack, user_out_data, user_out_vld, out_ack,
`ifdef LEAF_FIFO_STATS_EN
        output stats_clr,
        input  xfer_count,
`endif
        input  in_ack, user_in_data, user_in_vld, user_out_ack, out_data, out_vld, fifo_level
    );

    modport slave (
        input  resend, in_data, in_vld, user_in_ack, user_out_data, user_out_vld, out_ack,
`ifdef LEAF_FIFO_STATS_EN
        input  stats_clr,
        output xfer_count,
`endif
        output in_ack, user_in_data, user_in_vld, user_out_ack, out_data, out_vld, fifo_level
    );
endinterface

// File: rtl/leaf_user_fifo_bank.sv
// Purpose: provides an independent FWFT FIFO per inbound (interface->user) and outbound (user->interface) channel.
// Latency: a word pushed into an empty FIFO appears at the head 1 cycle later. There is no bypass.
// Backpressure: the writer-side ack equals !full. While resend is high, outbound vld is held at 0 and outbound pops are frozen.
// Ports: clk and reset_n (asynchronous, active-low) are plain ports. All other signals travel in bus (leaf_user_fifo_bank_if.slave).
// Optional macro LEAF_FIFO_STATS_EN adds saturating 16-bit per-FIFO push counters (xfer_count) and a synchronous clear (stats_clr).

// Generic circular-buffer FWFT FIFO. The head data is forced to zero when the FIFO is empty,
// so the data outputs read 0 after reset even though the storage itself is never reset.
module leaf_fifo #(
    parameter int W  = 32,
    parameter int DB = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_vld_i,
    input  logic [W-1:0]  wr_dat_i,
    output logic          wr_rdy_o,
    output logic          rd_vld_o,
    output logic [W-1:0]  rd_dat_o,
    input  logic          rd_rdy_i,
    input  logic          hold_i,
    output logic [DB:0]   level_o
);
    localparam int          DEPTH    = 1 << DB;
    localparam logic [DB:0] FULL_CNT = {1'b1, {DB{1'b0}}};
    localparam logic [DB:0] CNT_ONE  = 1;
    localparam logic [DB-1:0] PTR_ONE = 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [DB-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DB:0]   cnt_q, cnt_d;
    logic          full, empty, push, pop;

    assign full  = (cnt_q == FULL_CNT);
    assign empty = (cnt_q == '0);
    // A full FIFO refuses a push even when a pop frees a slot on the same edge.
    assign push  = wr_vld_i && !full;
    assign pop   = !empty && !hold_i && rd_rdy_i;

    assign wr_rdy_o = !full;
    assign rd_vld_o = !empty && !hold_i;
    assign rd_dat_o = empty ? '0 : mem_q[rd_ptr_q];
    assign level_o  = cnt_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_dat_i;
    end
endmodule

module leaf_user_fifo_bank #(
    parameter int PAYLOAD_BITS  = 32,
    parameter int NUM_IN_PORTS  = 4,
    parameter int NUM_OUT_PORTS = 3,
    parameter int DEPTH_BITS    = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    leaf_user_fifo_bank_if.slave bus
);
    localparam int W  = PAYLOAD_BITS;
    localparam int LW = DEPTH_BITS + 1;
    localparam int NI = NUM_IN_PORTS;
    localparam int NO = NUM_OUT_PORTS;

    logic [NI-1:0]         in_ack_w, user_in_vld_w;
    logic [NI*W-1:0]       user_in_data_w;
    logic [NO-1:0]         user_out_ack_w, out_vld_w;
    logic [NO*W-1:0]       out_data_w;
    logic [(NI+NO)*LW-1:0] level_w;

    for (genvar i = 0; i < NI; i++) begin : g_in
        leaf_fifo #(.W(W), .DB(DEPTH_BITS)) u_fifo (
            .clk      (clk),
            .reset_n  (reset_n),
            .wr_vld_i (bus.in_vld[i]),
            .wr_dat_i (bus.in_data[i*W +: W]),
            .wr_rdy_o (in_ack_w[i]),
            .rd_vld_o (user_in_vld_w[i]),
            .rd_dat_o (user_in_data_w[i*W +: W]),
            .rd_rdy_i (bus.user_in_ack[i]),
            .hold_i   (1'b0),
            .level_o  (level_w[i*LW +: LW])
        );
    end

    // Outbound FIFOs keep filling during resend. Only the interface-side pop is frozen.
    for (genvar j = 0; j < NO; j++) begin : g_out
        leaf_fifo #(.W(W), .DB(DEPTH_BITS)) u_fifo (
            .clk      (clk),
            .reset_n  (reset_n),
            .wr_vld_i (bus.user_out_vld[j]),
            .wr_dat_i (bus.user_out_data[j*W +: W]),
            .wr_rdy_o (user_out_ack_w[j]),
            .rd_vld_o (out_vld_w[j]),
            .rd_dat_o (out_data_w[j*W +: W]),
            .rd_rdy_i (bus.out_ack[j]),
            .hold_i   (bus.resend),
            .level_o  (level_w[(NI+j)*LW +: LW])
        );
    end

    assign bus.in_ack       = in_ack_w;
    assign bus.user_in_vld  = user_in_vld_w;
    assign bus.user_in_data = user_in_data_w;
    assign bus.user_out_ack = user_out_ack_w;
    assign bus.out_vld      = out_vld_w;
    assign bus.out_data     = out_data_w;
    assign bus.fifo_level   = level_w;

`ifdef LEAF_FIFO_STATS_EN
    // An accepted push is the writer's vld qualified by the FIFO's own !full ack.
    logic [NI+NO-1:0] acc_w;
    assign acc_w = {bus.user_out_vld & user_out_ack_w, bus.in_vld & in_ack_w};

    for (genvar f = 0; f < NI + NO; f++) begin : g_stat
        logic [15:0] xfer_q;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)
                xfer_q <= '0;
            else if (bus.stats_clr)
                xfer_q <= '0;
            else if (acc_w[f] && (xfer_q != 16'hFFFF))
                xfer_q <= xfer_q + 16'd1;
        end
        assign bus.xfer_count[f*16 +: 16] = xfer_q;
    end
`endif
endmodule

// File: tb/tb_leaf_user_fifo_bank.sv
// Purpose: self-checking bench for leaf_user_fifo_bank using a queue-based model, per-cycle comparison and directed vectors.
// Latency: inputs are driven 2 time units after each rising edge, and outputs are compared on the falling edge.
// Backpressure: the bench's kernel and interface hold vld until the model reports that the word was accepted.
module tb_leaf_user_fifo_bank;
    localparam int W  = 32;
    localparam int NI = 4;
    localparam int NO = 3;
    localparam int DB = 3;
    localparam int NF = NI + NO;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    bit   cmp_en = 1'b0;

    logic [W-1:0] mq [NF][$];

    leaf_user_fifo_bank_if #(.PAYLOAD_BITS(W), .NUM_IN_PORTS(NI), .NUM_OUT_PORTS(NO), .DEPTH_BITS(DB)) bus ();

    leaf_user_fifo_bank #(.PAYLOAD_BITS(W), .NUM_IN_PORTS(NI), .NUM_OUT_PORTS(NO), .DEPTH_BITS(DB)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] lvl(input int f);
        return bus.fifo_level[f*4 +: 4];
    endfunction

    function automatic logic [W-1:0] in_head(input int k);
        return bus.user_in_data[k*W +: W];
    endfunction

    function automatic logic [W-1:0] out_head(input int k);
        return bus.out_data[k*W +: W];
    endfunction

    // Model: each FIFO is a queue of at most DEPTH words. A push lands when the writer is valid and the queue is not full (judged before the edge).
    // A pop happens when the queue is non-empty, the reader acks, and (for outbound FIFOs) resend is low.
    always @(posedge clk) begin
        if (reset_n) begin
            for (int f = 0; f < NF; f++) begin
                int sz;
                bit pu, po;
                logic [W-1:0] wd;
                sz = mq[f].size();
                if (f < NI) begin
                    pu = bus.in_vld[f] && (sz < DEPTH);
                    po = (sz > 0) && bus.user_in_ack[f];
                    wd = bus.in_data[f*W +: W];
                end else begin
                    pu = bus.user_out_vld[f-NI] && (sz < DEPTH);
                    po = (sz > 0) && bus.out_ack[f-NI] && !bus.resend;
                    wd = bus.user_out_data[(f-NI)*W +: W];
                end
                if (po) void'(mq[f].pop_front());
                if (pu) mq[f].push_back(wd);
            end
        end
    end

    always @(negedge reset_n) begin
        for (int f = 0; f < NF; f++) mq[f].delete();
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int f = 0; f < NF; f++) begin
                int sz;
                logic [W-1:0] hd;
                sz = mq[f].size();
                hd = (sz > 0) ? mq[f][0] : '0;
                chk($sformatf("level%0d", f), lvl(f), sz);
                if (f < NI) begin
                    chk($sformatf("in_ack%0d", f), bus.in_ack[f], sz < DEPTH);
                    chk($sformatf("user_in_vld%0d", f), bus.user_in_vld[f], sz > 0);
                    chk($sformatf("user_in_data%0d", f), in_head(f), hd);
                end else begin
                    chk($sformatf("user_out_ack%0d", f-NI), bus.user_out_ack[f-NI], sz < DEPTH);
                    chk($sformatf("out_vld%0d", f-NI), bus.out_vld[f-NI], (sz > 0) && !bus.resend);
                    chk($sformatf("out_data%0d", f-NI), out_head(f-NI), hd);
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] exp1 [3];
        exp1[0] = 32'h11; exp1[1] = 32'h22; exp1[2] = 32'h33;

        bus.resend = 0; bus.in_data = '0; bus.in_vld = '0; bus.user_in_ack = '0;
        bus.user_out_data = '0; bus.user_out_vld = '0; bus.out_ack = '0;
`ifdef LEAF_FIFO_STATS_EN
        bus.stats_clr = 0;
`endif
        #3;
        chk("rst_in_ack", bus.in_ack, 4'hF);
        chk("rst_user_out_ack", bus.user_out_ack, 3'h7);
        chk("rst_user_in_vld", bus.user_in_vld, 0);
        chk("rst_out_vld", bus.out_vld, 0);
        chk("rst_level", bus.fifo_level, 0);
        chk("rst_user_in_data", bus.user_in_data, 0);
        chk("rst_out_data", bus.out_data, 0);
        tick();
        reset_n = 1;
        cmp_en  = 1;
        tick();

        // Inbound port 2: 3 pushes, then drain in order.
        bus.in_vld[2] = 1; bus.in_data[2*W +: W] = 32'h11;
        #1 chk("t1_no_bypass", bus.user_in_vld[2], 0);
        tick();
        chk("t1_vld_rise", bus.user_in_vld[2], 1);
        chk("t1_head0", in_head(2), 32'h11);
        bus.in_data[2*W +: W] = 32'h22; tick();
        bus.in_data[2*W +: W] = 32'h33; tick();
        bus.in_vld[2] = 0;
        chk("t1_level3", lvl(2), 4'd3);
        bus.user_in_ack[2] = 1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t1_pop%0d", i), in_head(2), exp1[i]);
            tick();
        end
        bus.user_in_ack[2] = 0;
        chk("t1_vld_drop", bus.user_in_vld[2], 0);

        // Outbound port 0: fill to full, hold a 9th word, then free one slot.
        bus.user_out_vld[0] = 1;
        for (int i = 0; i < 8; i++) begin
            bus.user_out_data[0 +: W] = 32'hA0 + i;
            tick();
        end
        chk("t2_full_ack", bus.user_out_ack[0], 0);
        bus.user_out_data[0 +: W] = 32'hA8;
        tick(2);
        chk("t2_level8", lvl(NI+0), 4'd8);
        bus.out_ack[0] = 1;
        tick();
        bus.out_ack[0] = 0;
        chk("t2_ack_back", bus.user_out_ack[0], 1);
        chk("t2_level7", lvl(NI+0), 4'd7);
        tick();
        bus.user_out_vld[0] = 0;
        chk("t2_level8b", lvl(NI+0), 4'd8);
        bus.out_ack[0] = 1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t2_drain%0d", i), out_head(0), 32'hA1 + i);
            tick();
        end
        bus.out_ack[0] = 0;
        chk("t2_empty", bus.out_vld[0], 0);

        // Inbound port 1: steady push+pop at count 4, which wraps the pointers.
        bus.in_vld[1] = 1;
        for (int i = 0; i < 4; i++) begin
            bus.in_data[1*W +: W] = 32'h40 + i;
            tick();
        end
        bus.user_in_ack[1] = 1;
        for (int i = 0; i < 10; i++) begin
            bus.in_data[1*W +: W] = 32'h44 + i;
            chk($sformatf("t3_head%0d", i), in_head(1), 32'h40 + i);
            tick();
            chk($sformatf("t3_level%0d", i), lvl(1), 4'd4);
        end
        bus.in_vld[1] = 0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_tail%0d", i), in_head(1), 32'h4A + i);
            tick();
        end
        bus.user_in_ack[1] = 0;
        chk("t3_empty", lvl(1), 4'd0);

        // Outbound port 1: resend freezes delivery.
        bus.user_out_vld[1] = 1;
        for (int i = 0; i < 5; i++) begin
            bus.user_out_data[1*W +: W] = 32'hB0 + i;
            tick();
        end
        bus.user_out_vld[1] = 0;
        bus.resend = 1; bus.out_ack[1] = 1;
        #1 chk("t4_vld_forced0", bus.out_vld[1], 0);
        tick(20);
        chk("t4_hold_vld", bus.out_vld[1], 0);
        chk("t4_hold_level", lvl(NI+1), 4'd5);
        chk("t4_user_ack", bus.user_out_ack[1], 1);
        bus.resend = 0;
        #1 chk("t4_vld_back", bus.out_vld[1], 1);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t4_word%0d", i), out_head(1), 32'hB0 + i);
            tick();
        end
        bus.out_ack[1] = 0;
        chk("t4_done", lvl(NI+1), 4'd0);

        // Asynchronous reset mid-burst.
        bus.in_vld[0] = 1; bus.in_data[0 +: W] = 32'hC0;
        bus.user_out_vld[2] = 1; bus.user_out_data[2*W +: W] = 32'hD0;
        tick(3);
        #1 reset_n = 0;
        #1;
        chk("t5_user_in_vld", bus.user_in_vld, 0);
        chk("t5_out_vld", bus.out_vld, 0);
        chk("t5_level", bus.fifo_level, 0);
        chk("t5_in_ack", bus.in_ack, 4'hF);
        chk("t5_user_out_ack", bus.user_out_ack, 3'h7);
        bus.in_vld = '0; bus.user_out_vld = '0;
        tick();
        reset_n = 1;
        bus.in_vld[3] = 1; bus.in_data[3*W +: W] = 32'h77;
        tick();
        bus.in_vld[3] = 0;
        chk("t5_fresh_level", lvl(3), 4'd1);
        chk("t5_fresh_head", in_head(3), 32'h77);
        chk("t5_other_level", lvl(0), 4'd0);
        bus.user_in_ack[3] = 1;
        tick();
        bus.user_in_ack[3] = 0;

`ifdef LEAF_FIFO_STATS_EN
        bus.in_vld[0] = 1; bus.user_in_ack[0] = 1;
        for (int i = 0; i < 70000; i++) begin
            bus.in_data[0 +: W] = i;
            tick();
        end
        bus.in_vld[0] = 0;
        tick(2);
        bus.user_in_ack[0] = 0;
        chk("t6_sat", bus.xfer_count[0 +: 16], 16'hFFFF);
        bus.stats_clr = 1;
        tick();
        bus.stats_clr = 0;
        chk("t6_clr", bus.xfer_count[0 +: 16], 16'h0);
`endif

        tick(2);
        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
